fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the multi-cycle RV32 core.
- Decouples instruction fetch from execute: sequential words are prefetched from the memory subsystem over its ce/busy/valid handshake into a DEPTH-entry queue, and each word is presented to decode together with its PC.
- Sits between `memory` (instruction port) and `control`/decode. Replaces the single `iword` register and the fetch-phase address mux.
- On a taken branch, jump, ISR entry or mret, the queue and any in-flight fetch are flushed.

---
 rtl/fetch_queue.sv | 199 +++++++++++++++++++
 tb/tb_fetch_queue.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_queue                                                  |
// | Description : Instruction prefetch queue between the memory instruction    |
// |               port and decode. Requests sequential words over the          |
// |               ce/busy/valid handshake, buffers DEPTH {word, pc} entries    |
// |               and flushes on redirect (branch, jump, ISR entry, mret).     |
// |               Optional macro FETCH_STALL_CNT_EN adds a saturating          |
// |               stall_count output.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_queue #(
    parameter int                  PC_WIDTH = 16,
    parameter int                  DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                mem_ce,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic                mem_busy,
    input  logic                mem_valid,
    input  logic [31:0]         mem_rdata,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                iword_valid,
    output logic [31:0]         iword,
    output logic [PC_WIDTH-1:0] iword_pc,
    input  logic                iword_ready,
    output logic                pc_misaligned
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]         stall_count
`endif
);

    localparam int                  c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW-1:0]     c_PTR_ONE  = c_AW'(1);
    localparam logic [c_AW:0]       c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW:0]       c_FULL     = (c_AW + 1)'(DEPTH);
    localparam logic [PC_WIDTH-1:0] c_PC_STEP  = PC_WIDTH'(4);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_AW:0]       r_count;
    logic [31:0]         r_word_mem [DEPTH];
    logic [PC_WIDTH-1:0] r_pc_mem   [DEPTH];

    logic                r_mem_ce;
    logic [PC_WIDTH-1:0] r_mem_addr;
    logic                r_iword_valid;
    logic [31:0]         r_iword;
    logic [PC_WIDTH-1:0] r_iword_pc;
    logic                r_pc_misaligned;

    logic                w_push;
    logic                w_pop;
    logic                w_issue;
    logic [c_AW:0]       w_count_next;
    logic [c_AW:0]       w_count_after_pop;
    logic [c_AW-1:0]     w_rd_next;
    logic [31:0]         w_head_word;
    logic [PC_WIDTH-1:0] w_head_pc;
    logic [PC_WIDTH-1:0] w_redirect_aligned;

    assign w_redirect_aligned = {redirect_pc[PC_WIDTH-1:2], 2'b00};

    // A redirect cancels every queue update in its cycle; reset blocks writes.
    assign w_push  = reset && !redirect && (r_state == ST_WAIT) && mem_valid;
    assign w_pop   = reset && !redirect && r_iword_valid && iword_ready;
    assign w_issue = (r_state == ST_IDLE) && (r_count < c_FULL) && !mem_busy && !redirect;

    // Next occupancy and next head entry; a word written into a queue that is
    // empty after this cycle's pop is taken from the memory bus directly.
    always_comb begin
        w_count_next      = r_count;
        w_count_after_pop = w_pop ? (r_count - c_CNT_ONE) : r_count;
        w_rd_next         = w_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_CNT_ONE;
        end
        if (w_push && (w_count_after_pop == '0)) begin
            w_head_word = mem_rdata;
            w_head_pc   = r_mem_addr;
        end else begin
            w_head_word = r_word_mem[w_rd_next];
            w_head_pc   = r_pc_mem[w_rd_next];
        end
    end

    // Queue storage: one entry written per returned word.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_word_mem[r_wr_ptr] <= mem_rdata;
            r_pc_mem[r_wr_ptr]   <= r_mem_addr;
        end
    end

    // Fetch FSM, queue pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_fetch_pc      <= RESET_PC;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_mem_ce        <= 1'b0;
            r_mem_addr      <= RESET_PC;
            r_iword_valid   <= 1'b0;
            r_iword         <= '0;
            r_iword_pc      <= '0;
            r_pc_misaligned <= 1'b0;
        end else begin
            r_mem_ce        <= 1'b0;
            r_pc_misaligned <= 1'b0;
            if (redirect) begin
                r_fetch_pc      <= w_redirect_aligned;
                r_pc_misaligned <= |redirect_pc[1:0];
                r_wr_ptr        <= '0;
                r_rd_ptr        <= '0;
                r_count         <= '0;
                r_iword_valid   <= 1'b0;
                // An outstanding request must still be drained; if its
                // response lands in this very cycle there is nothing left.
                case (r_state)
                    ST_WAIT:    r_state <= mem_valid ? ST_IDLE : ST_DISCARD;
                    ST_DISCARD: r_state <= mem_valid ? ST_IDLE : ST_DISCARD;
                    default:    r_state <= ST_IDLE;
                endcase
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_issue) begin
                            r_mem_ce   <= 1'b1;
                            r_mem_addr <= r_fetch_pc;
                            r_state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (mem_valid) begin
                            r_fetch_pc <= r_fetch_pc + c_PC_STEP;
                            r_state    <= ST_IDLE;
                        end
                    end
                    ST_DISCARD: begin
                        if (mem_valid) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                r_rd_ptr      <= w_rd_next;
                r_count       <= w_count_next;
                r_iword_valid <= (w_count_next != '0);
                if (w_count_next != '0) begin
                    r_iword    <= w_head_word;
                    r_iword_pc <= w_head_pc;
                end
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_count;

    // Count cycles where decode is ready but no word is available; saturates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_count <= '0;
        end else if (iword_ready && !r_iword_valid && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

    assign mem_ce        = r_mem_ce;
    assign mem_addr      = r_mem_addr;
    assign iword_valid   = r_iword_valid;
    assign iword         = r_iword;
    assign iword_pc      = r_iword_pc;
    assign pc_misaligned = r_pc_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_queue                                               |
// | Description : Directed self-checking bench for fetch_queue with a          |
// |               latency-configurable memory model and an expected-word       |
// |               queue filled as the memory answers.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_queue;

    localparam int          PC_WIDTH = 16;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_ce;
    logic [15:0] mem_addr;
    logic        mem_busy;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        iword_valid;
    logic [31:0] iword;
    logic [15:0] iword_pc;
    logic        iword_ready;
    logic        pc_misaligned;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    always #5 clk = ~clk;

    fetch_queue #(
        .PC_WIDTH (PC_WIDTH),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_ce        (mem_ce),
        .mem_addr      (mem_addr),
        .mem_busy      (mem_busy),
        .mem_valid     (mem_valid),
        .mem_rdata     (mem_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .iword_valid   (iword_valid),
        .iword         (iword),
        .iword_pc      (iword_pc),
        .iword_ready   (iword_ready),
        .pc_misaligned (pc_misaligned)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_count   (stall_count)
`endif
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] word;
    } entry_t;

    int          errors = 0;
    int          checks = 0;
    entry_t      exp_q[$];

    // Memory model: lat = edges between the edge that samples mem_ce and the
    // edge that samples mem_valid.
    int          lat        = 1;
    int          timer      = 0;
    logic [15:0] pend_addr  = '0;
    logic [31:0] pend_word  = '0;
    int          pend_epoch = 0;
    int          epoch      = 0;
    logic [15:0] exp_fetch  = RESET_PC;
    int          n_req      = 0;
    logic [15:0] last_req   = '0;
    int          n_pop      = 0;
    logic [15:0] last_pop_pc = '0;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the pop/redirect of the current cycle, advance, then
    // let the memory model react to the DUT outputs of the new cycle.
    task automatic step();
        entry_t e;
        if (reset && redirect) begin
            exp_q.delete();
            epoch++;
            exp_fetch = {redirect_pc[15:2], 2'b00};
        end else if (reset && iword_valid && iword_ready) begin
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("pop_iword_pc", 64'(iword_pc), 64'(e.pc));
                chk("pop_iword", 64'(iword), 64'(e.word));
                n_pop++;
                last_pop_pc = iword_pc;
            end
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        if (!reset) begin
            timer     = 0;
            mem_busy  = 1'b0;
            exp_q.delete();
            exp_fetch = RESET_PC;
        end else begin
            if (timer > 0) begin
                timer--;
                if (timer == 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = pend_word;
                    if (pend_epoch == epoch) exp_q.push_back({pend_addr, pend_word});
                end
            end
            if (mem_ce) begin
                chk("one_outstanding", 64'(timer), 64'd0);
                chk("req_addr", 64'(mem_addr), 64'(exp_fetch));
                exp_fetch  = exp_fetch + 16'd4;
                n_req++;
                last_req   = mem_addr;
                timer      = lat;
                pend_addr  = mem_addr;
                pend_word  = mem_word(mem_addr);
                pend_epoch = epoch;
            end
            mem_busy = (timer > 0);
        end
    endtask

    task automatic wait_ce(input string tag, input int max_cycles);
        int i = 0;
        while (!mem_ce && i < max_cycles) begin
            step();
            i++;
        end
        chk(tag, 64'(mem_ce), 64'd1);
    endtask

    task automatic wait_pop(input string tag, input int max_cycles);
        int p0 = n_pop;
        int i  = 0;
        while (n_pop == p0 && i < max_cycles) begin
            step();
            i++;
        end
        chk(tag, 64'(n_pop - p0), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        iword_ready = 1'b0;
        mem_busy    = 1'b0;
        mem_valid   = 1'b0;
        mem_rdata   = '0;

        // Reset state
        repeat (3) step();
        chk("rst_mem_ce", 64'(mem_ce), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'(RESET_PC));
        chk("rst_iword_valid", 64'(iword_valid), 64'd0);
        chk("rst_iword", 64'(iword), 64'd0);
        chk("rst_iword_pc", 64'(iword_pc), 64'd0);
        chk("rst_pc_misaligned", 64'(pc_misaligned), 64'd0);

        // Sequential fetch from reset, always-ready consumer
        lat = 1;
        iword_ready = 1'b1;
        reset = 1'b1;
        step();
        chk("first_ce", 64'(mem_ce), 64'd1);
        repeat (20) step();
        chk("seq_pops_min3", 64'(n_pop >= 3), 64'd1);

        // Fill with a stalled consumer
        reset = 1'b0;
        iword_ready = 1'b0;
        repeat (2) step();
        n_req = 0;
        reset = 1'b1;
        repeat (30) step();
        chk("fill_req_count", 64'(n_req), 64'd4);
        chk("fill_head_valid", 64'(iword_valid), 64'd1);
        chk("fill_head_pc", 64'(iword_pc), 64'h0000);
        chk("fill_head_word", 64'(iword), 64'(mem_word(16'h0000)));
        iword_ready = 1'b1;
        step();
        iword_ready = 1'b0;
        repeat (10) step();
        chk("refill_req_count", 64'(n_req), 64'd5);
        chk("refill_addr", 64'(last_req), 64'h0010);
        chk("head_after_pop", 64'(iword_pc), 64'h0004);

        // Redirect while a request is outstanding
        lat = 4;
        iword_ready = 1'b1;
        step();
        wait_ce("t3_ce_seen", 30);
        pend_word = 32'hDEAD_BEEF;
        redirect = 1'b1;
        redirect_pc = 16'h0120;
        step();
        redirect = 1'b0;
        chk("t3_valid_cleared", 64'(iword_valid), 64'd0);
        chk("t3_aligned_no_pulse", 64'(pc_misaligned), 64'd0);
        wait_pop("t3_pop_seen", 40);
        chk("t3_next_pc", 64'(last_pop_pc), 64'h0120);

        // Redirect in the same cycle as a response
        lat = 1;
        begin
            int i = 0;
            while (!mem_valid && i < 20) begin
                step();
                i++;
            end
        end
        chk("t4_valid_seen", 64'(mem_valid), 64'd1);
        redirect = 1'b1;
        redirect_pc = 16'h0200;
        step();
        redirect = 1'b0;
        wait_ce("t4_ce_seen", 3);
        chk("t4_ce_addr", 64'(mem_addr), 64'h0200);
        wait_pop("t4_pop_seen", 20);
        chk("t4_next_pc", 64'(last_pop_pc), 64'h0200);

        // Misaligned target and address wrap
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        chk("misaligned_pulse", 64'(pc_misaligned), 64'd1);
        step();
        chk("misaligned_one_cycle", 64'(pc_misaligned), 64'd0);
        wait_ce("t5_ce1_seen", 20);
        chk("wrap_first_addr", 64'(mem_addr), 64'hFFFC);
        step();
        wait_ce("t5_ce2_seen", 20);
        chk("wrap_second_addr", 64'(mem_addr), 64'h0000);
        repeat (6) step();

`ifdef FETCH_STALL_CNT_EN
        // Stall counter with a slow memory (strobe cycle through response
        // cycle spans 10 cycles)
        reset = 1'b0;
        repeat (2) step();
        chk("stall_rst", 64'(stall_count), 64'd0);
        lat = 9;
        iword_ready = 1'b1;
        reset = 1'b1;
        begin
            int i = 0;
            while (!iword_valid && i < 40) begin
                step();
                i++;
            end
        end
        chk("stall_first_word_valid", 64'(iword_valid), 64'd1);
        chk("stall_first_word", 64'(stall_count), 64'd11);
`endif

        // Reset while a request is outstanding
        lat = 9;
        iword_ready = 1'b1;
        wait_ce("t6_ce_seen", 30);
        repeat (2) step();
        reset = 1'b0;
        step();
        chk("midwait_rst_ce", 64'(mem_ce), 64'd0);
`ifdef FETCH_STALL_CNT_EN
        chk("midwait_stall_cleared", 64'(stall_count), 64'd0);
`endif
        reset = 1'b1;
        step();
        chk("midwait_release_ce", 64'(mem_ce), 64'd1);
        chk("midwait_release_addr", 64'(mem_addr), 64'(RESET_PC));
        repeat (15) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
